// File: rtl/msg_formatter_tx.sv
// ASCII frame formatter for the UART transmitter.
// Builds "{Rddd,Gddd,Bddd}" or "{L016}"/"{L017}" and streams it one byte per tx_start/tx_done handshake.
module msg_formatter_tx #(
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r_val,
  input  logic [7:0] g_val,
  input  logic [7:0] b_val,
  input  logic       rgb_send,
  input  logic       led_sel,
  input  logic       led_send,
  input  logic       tx_done,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        state, state_next;
  logic [3:0]    idx, idx_next;
  logic          rgb_frame;
  logic          led_bit;
  logic [11:0]   r_dig, g_dig, b_dig;
  logic [7:0]    gap_cnt;
  logic [TW-1:0] timer;
  logic          accept_rgb, accept_led;
  logic          finish, abort;
  logic          last_idx;
  logic [7:0]    next_byte;

  // Three BCD digits, leading zeros kept.
  function automatic logic [11:0] to_digits(input logic [7:0] v);
    return {4'(v / 8'd100), 4'((v % 8'd100) / 8'd10), 4'(v % 8'd10)};
  endfunction

  assign tx_start = (state == LOAD);
  assign busy     = (state != IDLE);
  assign last_idx = rgb_frame ? (idx == 4'd15) : (idx == 4'd5);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept_rgb = 1'b0;
    accept_led = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        // No acceptance while the end-of-frame pulse is still showing.
        if (!frame_done && !timeout_err) begin
          if (rgb_send) begin
            accept_rgb = 1'b1;
            idx_next   = 4'd0;
            state_next = LOAD;
          end else if (led_send) begin
            accept_led = 1'b1;
            idx_next   = 4'd0;
            state_next = LOAD;
          end
        end
      end
      LOAD: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          if (last_idx) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next   = idx + 4'd1;
            state_next = (GAP_CYCLES > 0) ? GAP : LOAD;
          end
        end else if (timer >= TIMER_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    next_byte = 8'h7D;
    if (rgb_frame) begin
      case (idx_next)
        4'd0:    next_byte = 8'h7B;
        4'd1:    next_byte = 8'h52;
        4'd2:    next_byte = {4'h3, r_dig[11:8]};
        4'd3:    next_byte = {4'h3, r_dig[7:4]};
        4'd4:    next_byte = {4'h3, r_dig[3:0]};
        4'd5:    next_byte = 8'h2C;
        4'd6:    next_byte = 8'h47;
        4'd7:    next_byte = {4'h3, g_dig[11:8]};
        4'd8:    next_byte = {4'h3, g_dig[7:4]};
        4'd9:    next_byte = {4'h3, g_dig[3:0]};
        4'd10:   next_byte = 8'h2C;
        4'd11:   next_byte = 8'h42;
        4'd12:   next_byte = {4'h3, b_dig[11:8]};
        4'd13:   next_byte = {4'h3, b_dig[7:4]};
        4'd14:   next_byte = {4'h3, b_dig[3:0]};
        default: next_byte = 8'h7D;
      endcase
    end else begin
      case (idx_next)
        4'd0:    next_byte = 8'h7B;
        4'd1:    next_byte = 8'h4C;
        4'd2:    next_byte = 8'h30;
        4'd3:    next_byte = 8'h31;
        4'd4:    next_byte = {7'b0011011, led_bit};
        default: next_byte = 8'h7D;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 4'd0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      tx_byte     <= 8'h00;
      timer       <= '0;
      gap_cnt     <= 8'd0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      frame_done  <= finish;
      timeout_err <= abort;
      // Byte index 0 is always '{', so the stale frame type is harmless at acceptance.
      if (state_next == LOAD) begin
        tx_byte <= next_byte;
      end
      // Timer counts clocks since tx_start.
      if (state_next == LOAD) begin
        timer <= '0;
      end else if (state == LOAD || state == WAIT_DONE) begin
        timer <= timer + 1'b1;
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 8'd1;
      end else begin
        gap_cnt <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_frame <= 1'b0;
      led_bit   <= 1'b0;
      r_dig     <= 12'd0;
      g_dig     <= 12'd0;
      b_dig     <= 12'd0;
    end else if (accept_rgb) begin
      rgb_frame <= 1'b1;
      r_dig     <= to_digits(r_val);
      g_dig     <= to_digits(g_val);
      b_dig     <= to_digits(b_val);
    end else if (accept_led) begin
      rgb_frame <= 1'b0;
      led_bit   <= led_sel;
    end
  end

endmodule
